// File: rtl/i2c_target_regfile.sv
// I2C target holding a byte-wide register file; oversamples scl/sda on core_clk.
// Write: addr+W, pointer byte, data bytes (auto-increment). Read: addr+R streams from the pointer.
module i2c_target_regfile #(
  parameter logic [6:0]  TGT_ADDR = 7'h50,
  parameter int unsigned NREG     = 8,
  parameter int unsigned PW       = 3
) (
  input  logic                core_clk,
  input  logic                core_rst,
  input  logic                scl_i,
  input  logic                sda_i,
  output logic                sda_oe,
  output logic [8*NREG-1:0]   regs_flat,
  output logic [PW-1:0]       ptr,
  output logic                busy,
  output logic                wr_strobe
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK,
    RDATA, RACK, RNEXT, WAIT_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    scl_s_q, sda_s_q;
  logic          scl_h_q, sda_h_q;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;
  logic          rw_q, rw_d;
  logic          sda_oe_q, sda_oe_d;
  logic          wr_q, wr_d;
  logic          reg_we;
  logic [7:0]    regs_q [NREG];

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_w;

  assign scl_s     = scl_s_q[1];
  assign sda_s     = sda_s_q[1];
  assign scl_rise  = scl_s & ~scl_h_q;
  assign scl_fall  = ~scl_s & scl_h_q;
  assign start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;
  assign byte_w    = {sh_q[6:0], sda_s};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    rw_d     = rw_q;
    sda_oe_d = sda_oe_q;
    wr_d     = 1'b0;
    reg_we   = 1'b0;
    if (start_det) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            sh_d  = byte_w;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (byte_w[7:1] == TGT_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = byte_w[0];
                end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                ptr_d   = byte_w[PW-1:0];
                state_d = PTR_ACK;
              end else begin
                reg_we  = 1'b1;
                wr_d    = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                state_d = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // first fall after the 8th bit starts the ACK, the next one ends it
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              if (state_q == ADDR_ACK && rw_q) begin
                sh_d     = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
                state_d  = RDATA;
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = RACK;
          end else if (scl_fall) begin
            sh_d     = {sh_q[6:0], sh_q[7]};
            sda_oe_d = ~sh_q[6];
          end
        end
        RACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = sda_s ? WAIT_STOP : RNEXT;
          end
        end
        RNEXT: begin
          if (scl_fall) begin
            sh_d     = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
            cnt_d    = '0;
            state_d  = RDATA;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q  <= IDLE;
      scl_s_q  <= '1;
      sda_s_q  <= '1;
      scl_h_q  <= 1'b1;
      sda_h_q  <= 1'b1;
      cnt_q    <= '0;
      sh_q     <= '0;
      ptr_q    <= '0;
      busy_q   <= 1'b0;
      rw_q     <= 1'b0;
      sda_oe_q <= 1'b0;
      wr_q     <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      scl_s_q  <= {scl_s_q[0], scl_i};
      sda_s_q  <= {sda_s_q[0], sda_i};
      scl_h_q  <= scl_s;
      sda_h_q  <= sda_s;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      rw_q     <= rw_d;
      sda_oe_q <= sda_oe_d;
      wr_q     <= wr_d;
      if (reg_we) regs_q[ptr_q] <= byte_w;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NREG; i++) regs_flat[8*i +: 8] = regs_q[i];
  end

  assign sda_oe    = sda_oe_q;
  assign ptr       = ptr_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_q;

endmodule
